// File: rtl/multicore_pkg.sv
// Shared pipeline types and constants for the memory-access stage.
package multicore_pkg;

    typedef enum logic [2:0] {
        LDOP_LB  = 3'b000,
        LDOP_LH  = 3'b001,
        LDOP_LW  = 3'b010,
        LDOP_LBU = 3'b100,
        LDOP_LHU = 3'b101
    } t_ldop;

    typedef enum logic [1:0] {
        SOP_SB = 2'b00,
        SOP_SH = 2'b01,
        SOP_SW = 2'b10
    } t_sop;

    typedef enum logic [1:0] {
        MA_IDLE,
        MA_REQ,
        MA_WAIT
    } t_ma_state;

    localparam logic [1:0] MEMTOREG_ALU = 2'b00;
    localparam logic [1:0] MEMTOREG_MEM = 2'b01;
    localparam logic [1:0] MEMTOREG_PC  = 2'b10;

    // Halfwords need addr[0]==0, words need addr[1:0]==0; bytes are always aligned.
    function automatic logic ma_misaligned(input logic      is_store,
                                           input t_ldop     ldop,
                                           input t_sop      sop,
                                           input logic [1:0] off);
        logic half;
        logic word;
        if (is_store) begin
            half = (sop == SOP_SH);
            word = (sop == SOP_SW);
        end else begin
            half = (ldop == LDOP_LH) || (ldop == LDOP_LHU);
            word = (ldop == LDOP_LW);
        end
        return (half && off[0]) || (word && (off != 2'b00));
    endfunction

endpackage

// File: rtl/load_store_align.sv
// Byte-lane steering for stores, load extraction/extension, and the misaligned flag.
module load_store_align
    import multicore_pkg::*;
#(
    parameter int DATA_SIZE = 32
) (
    input  logic                   i_is_store,
    input  t_ldop                  i_ldop,
    input  t_sop                   i_sop,
    input  logic [1:0]             i_addr_lo,
    input  logic [DATA_SIZE-1:0]   i_wdata,
    input  logic [DATA_SIZE-1:0]   i_rdata,
    output logic [DATA_SIZE/8-1:0] o_be,
    output logic [DATA_SIZE-1:0]   o_wdata,
    output logic [DATA_SIZE-1:0]   o_ldata,
    output logic                   o_misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign o_misaligned = ma_misaligned(i_is_store, i_ldop, i_sop, i_addr_lo);

    always_comb begin
        o_be    = '1;
        o_wdata = i_wdata;
        if (i_is_store) begin
            case (i_sop)
                SOP_SB: begin
                    o_be    = 4'b0001 << i_addr_lo;
                    o_wdata = {4{i_wdata[7:0]}};
                end
                SOP_SH: begin
                    o_be    = 4'b0011 << i_addr_lo;
                    o_wdata = {2{i_wdata[15:0]}};
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        byte_sel = i_rdata[{i_addr_lo, 3'b000} +: 8];
        half_sel = i_rdata[{i_addr_lo[1], 4'b0000} +: 16];
        case (i_ldop)
            LDOP_LB:  o_ldata = {{24{byte_sel[7]}}, byte_sel};
            LDOP_LBU: o_ldata = {24'b0, byte_sel};
            LDOP_LH:  o_ldata = {{16{half_sel[15]}}, half_sel};
            LDOP_LHU: o_ldata = {16'b0, half_sel};
            default:  o_ldata = i_rdata;
        endcase
    end

endmodule

// File: rtl/memory_access_unit.sv
// MEM pipeline stage: captures the EX bundle, runs the dmem req/ready/rvalid
// handshake and produces the write-back / forwarding value.
module memory_access_unit
    import multicore_pkg::*;
#(
    parameter int DATA_SIZE = 32,
    parameter int INST_SIZE = 32,
    parameter int NUM_REGS  = 32
) (
    input  logic                        i_aclk,
    input  logic                        i_areset_n,
    input  logic                        i_en,
    input  logic [DATA_SIZE-1:0]        i_exe_calc,
    input  logic [DATA_SIZE-1:0]        i_exe_wdata,
    input  logic [$clog2(NUM_REGS)-1:0] i_rdest,
    input  logic                        i_cu_regwrite,
    input  logic [1:0]                  i_cu_memtoreg,
    input  logic                        i_cu_memwrite,
    input  t_ldop                       i_ldop,
    input  t_sop                        i_sop,
    input  logic [INST_SIZE-1:0]        i_pcplus4,
    output logic                        o_stall,
    output logic                        o_dmem_req,
    output logic                        o_dmem_we,
    output logic [DATA_SIZE-1:0]        o_dmem_addr,
    output logic [DATA_SIZE/8-1:0]      o_dmem_be,
    output logic [DATA_SIZE-1:0]        o_dmem_wdata,
    input  logic                        i_dmem_ready,
    input  logic                        i_dmem_rvalid,
    input  logic [DATA_SIZE-1:0]        i_dmem_rdata,
    output logic [DATA_SIZE-1:0]        o_wb_data,
    output logic [$clog2(NUM_REGS)-1:0] o_rdest,
    output logic                        o_cu_regwrite,
    output logic [DATA_SIZE-1:0]        o_forward_data,
    output logic                        o_misaligned
);

    localparam int RW = $clog2(NUM_REGS);

    t_ma_state            state_q, state_d;
    logic [DATA_SIZE-1:0] calc_q, calc_d;
    logic [DATA_SIZE-1:0] wdata_q, wdata_d;
    logic [RW-1:0]        rdest_q, rdest_d;
    logic                 regwrite_q, regwrite_d;
    logic [1:0]           memtoreg_q, memtoreg_d;
    logic                 memwrite_q, memwrite_d;
    t_ldop                ldop_q, ldop_d;
    t_sop                 sop_q, sop_d;
    logic [INST_SIZE-1:0] pcplus4_q, pcplus4_d;

    logic                 stall;
    logic                 in_mem_op;
    logic                 in_misaligned;
    logic                 mem_op_q;
    logic                 align_mis;
    logic                 misaligned_q;
    logic [DATA_SIZE-1:0] ldata;

    assign in_mem_op     = i_en && (i_cu_memwrite || (i_cu_memtoreg == MEMTOREG_MEM));
    assign in_misaligned = ma_misaligned(i_cu_memwrite, i_ldop, i_sop, i_exe_calc[1:0]);
    assign mem_op_q      = memwrite_q || (memtoreg_q == MEMTOREG_MEM);
    assign misaligned_q  = mem_op_q && align_mis;

    load_store_align #(
        .DATA_SIZE(DATA_SIZE)
    ) u_align (
        .i_is_store  (memwrite_q),
        .i_ldop      (ldop_q),
        .i_sop       (sop_q),
        .i_addr_lo   (calc_q[1:0]),
        .i_wdata     (wdata_q),
        .i_rdata     (i_dmem_rdata),
        .o_be        (o_dmem_be),
        .o_wdata     (o_dmem_wdata),
        .o_ldata     (ldata),
        .o_misaligned(align_mis)
    );

    always_comb begin
        state_d    = state_q;
        stall      = 1'b0;
        o_dmem_req = 1'b0;
        case (state_q)
            MA_REQ: begin
                o_dmem_req = 1'b1;
                stall      = !(i_dmem_ready && (memwrite_q || i_dmem_rvalid));
                if (i_dmem_ready && !memwrite_q && !i_dmem_rvalid) begin
                    state_d = MA_WAIT;
                end
            end
            MA_WAIT: stall = !i_dmem_rvalid;
            default: ;
        endcase
        // Every unstalled edge is a capture edge, so the next state follows the
        // incoming bundle; this lets back-to-back ops go straight to REQ.
        if (!stall) begin
            state_d = (in_mem_op && !in_misaligned) ? MA_REQ : MA_IDLE;
        end
    end

    always_comb begin
        calc_d     = calc_q;
        wdata_d    = wdata_q;
        rdest_d    = rdest_q;
        regwrite_d = regwrite_q;
        memtoreg_d = memtoreg_q;
        memwrite_d = memwrite_q;
        ldop_d     = ldop_q;
        sop_d      = sop_q;
        pcplus4_d  = pcplus4_q;
        if (!stall) begin
            calc_d     = i_exe_calc;
            wdata_d    = i_exe_wdata;
            rdest_d    = i_rdest;
            ldop_d     = i_ldop;
            sop_d      = i_sop;
            pcplus4_d  = i_pcplus4;
            regwrite_d = i_en && i_cu_regwrite;
            memwrite_d = i_en && i_cu_memwrite;
            memtoreg_d = i_en ? i_cu_memtoreg : MEMTOREG_ALU;
        end
    end

    always_ff @(posedge i_aclk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            state_q    <= MA_IDLE;
            calc_q     <= '0;
            wdata_q    <= '0;
            rdest_q    <= '0;
            regwrite_q <= 1'b0;
            memtoreg_q <= MEMTOREG_ALU;
            memwrite_q <= 1'b0;
            ldop_q     <= LDOP_LB;
            sop_q      <= SOP_SB;
            pcplus4_q  <= '0;
        end else begin
            state_q    <= state_d;
            calc_q     <= calc_d;
            wdata_q    <= wdata_d;
            rdest_q    <= rdest_d;
            regwrite_q <= regwrite_d;
            memtoreg_q <= memtoreg_d;
            memwrite_q <= memwrite_d;
            ldop_q     <= ldop_d;
            sop_q      <= sop_d;
            pcplus4_q  <= pcplus4_d;
        end
    end

    always_comb begin
        case (memtoreg_q)
            MEMTOREG_MEM: o_wb_data = ldata;
            MEMTOREG_PC:  o_wb_data = DATA_SIZE'(pcplus4_q);
            default:      o_wb_data = calc_q;
        endcase
    end

    assign o_stall        = stall;
    assign o_dmem_we      = memwrite_q;
    assign o_dmem_addr    = {calc_q[DATA_SIZE-1:2], 2'b00};
    assign o_rdest        = rdest_q;
    assign o_cu_regwrite  = regwrite_q && !stall && !misaligned_q;
    assign o_forward_data = o_wb_data;
    assign o_misaligned   = misaligned_q;

endmodule

// File: doc/memory_access_unit.md
Name: memory_access_unit

Overview:
- Pipeline stage after execute. It consumes the execute-stage result bundle (calc, wdata, rdest, regwrite, memtoreg, memwrite, ldop, sop, pcplus4) and performs the load/store against data memory over a req/ready/rvalid handshake.
- It produces the write-back bundle and the memory-access forwarding value.
- It stalls the upstream pipeline while a memory transaction is outstanding.

Parameters:
- DATA_SIZE, 32, data/address width in bits; must be 32.
- INST_SIZE, 32, PC width.
- NUM_REGS, 32, register count; rdest width is $clog2(NUM_REGS).

Ports:
- i_aclk  in  1  clock
- i_areset_n  in  1  asynchronous, active-low reset
- i_en  in  1  incoming EX bundle valid; low loads a bubble
- i_exe_calc  in  DATA_SIZE  ALU/system result; the memory address for ld/st
- i_exe_wdata  in  DATA_SIZE  store data, right-aligned
- i_rdest  in  $clog2(NUM_REGS)  destination register
- i_cu_regwrite  in  1  write register file
- i_cu_memtoreg  in  2  WB source: 00 calc, 01 load data, 10 pcplus4
- i_cu_memwrite  in  1  store
- i_ldop  in  t_ldop  LB/LH/LW/LBU/LHU
- i_sop  in  t_sop  SB/SH/SW
- i_pcplus4  in  INST_SIZE  link value
- o_stall  out  1  hold EX and earlier stages
- o_dmem_req  out  1  request valid
- o_dmem_we  out  1  1 = store
- o_dmem_addr  out  DATA_SIZE  word-aligned address ({calc[31:2],2'b00})
- o_dmem_be  out  DATA_SIZE/8  byte enables
- o_dmem_wdata  out  DATA_SIZE  lane-shifted store data
- i_dmem_ready  in  1  request accepted this cycle
- i_dmem_rvalid  in  1  load data valid
- i_dmem_rdata  in  DATA_SIZE  load word
- o_wb_data  out  DATA_SIZE  write-back value
- o_rdest  out  $clog2(NUM_REGS)  write-back destination
- o_cu_regwrite  out  1  write-back enable (qualified)
- o_forward_data  out  DATA_SIZE  equals o_wb_data; drives the EX forward path
- o_misaligned  out  1  one-cycle pulse when a misaligned access is dropped

Behaviour:
- Stage register: on each rising edge with o_stall=0, captures the bundle.
  - If i_en=0, captures a bubble: regwrite=0, memwrite=0, memtoreg=00.
  - With o_stall=1, the register holds.
- Reset: stage register cleared to bubble, FSM to IDLE. o_dmem_req=0, o_stall=0, o_cu_regwrite=0, o_misaligned=0. Data outputs are don't-care.
- Mem op: the captured instruction has memwrite=1 or memtoreg=01.
- Alignment rules:
  - Misaligned when (LH/LHU/SH and addr[0]) or (LW/SW and addr[1:0]!=0).
  - A misaligned op issues no request and does not stall.
  - It pulses o_misaligned and forces o_cu_regwrite=0.
- FSM states: IDLE, REQ, WAIT.
  - IDLE: if a new aligned mem op is captured at an edge, go to REQ the same edge.
  - REQ: o_dmem_req=1 with addr/we/be/wdata held stable until i_dmem_ready.
    - On ready with store: go to IDLE.
    - On ready with load: go to WAIT.
    - On ready and i_dmem_rvalid in the same cycle with load: completes, go to IDLE.
  - WAIT: o_dmem_req=0. On i_dmem_rvalid, go to IDLE.
- o_stall is combinational:
  - 1 in REQ, except for (store & i_dmem_ready) or (load & ready & rvalid).
  - 1 in WAIT, except when i_dmem_rvalid=1.
  - 0 in IDLE.
- Completion cycle: the cycle o_stall drops.
  - o_cu_regwrite = captured regwrite & ~o_stall & ~misaligned.
  - Non-mem ops complete the cycle after capture, with zero stall.
- Store lanes:
  - SB: be=0001<<addr[1:0], wdata={4{b}}.
  - SH: be=0011<<addr[1:0], wdata={2{h}}.
  - SW: be=1111.
- Loads: select byte/half by addr[1:0] from i_dmem_rdata.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - Load data is used combinationally in the rvalid cycle; no capture register is needed.
- o_wb_data mux by memtoreg: 00 calc, 01 load data, 10 pcplus4, 11 calc.
- Boundary cases:
  - i_dmem_rvalid in IDLE or REQ without ready is ignored.
  - Reset while in REQ or WAIT: request is dropped immediately; a later rvalid is ignored.
  - Back-to-back mem ops: the next op is captured on the completion edge and enters REQ directly, with no idle cycle.
  - i_en changes during a stall have no effect.

Decomposition:
- multicore_pkg holds:
  - t_ldop and t_sop (existing).
  - New t_ma_state {MA_IDLE, MA_REQ, MA_WAIT}.
  - Constants MEMTOREG_ALU=2'b00, MEMTOREG_MEM=2'b01, MEMTOREG_PC=2'b10.
- One combinational sub-module, load_store_align:
  - Generates be and wdata lanes, load extraction and the misaligned flag.
  - The FSM and stage register stay in memory_access_unit.

Test Plan:
- ALU op, calc=0x1234, memtoreg=00, regwrite=1 -> next cycle o_wb_data=0x1234, o_cu_regwrite=1; o_stall never asserts; o_dmem_req=0.
- SB, calc=0x1003, wdata=0xAB, ready high immediately -> one-cycle req with addr=0x1000, be=1000, wdata=0xABABABAB, we=1; o_stall=0.
- LB, calc=0x2002, ready after 2 cycles, rvalid 3 cycles after ready, rdata=0x0080FF00 -> o_stall high for 5 cycles; completion gives o_wb_data=0xFFFFFF80 and regwrite=1. Same with LBU -> 0x00000080.
- LW, calc=0x3001 -> no req, o_misaligned=1 for one cycle, o_cu_regwrite=0, no stall.
- Reset asserted in WAIT, then rvalid pulses after reset release -> FSM IDLE, req=0, no regwrite.
- SH then LHU back-to-back, ready=rvalid=1 the same cycle -> each completes in one cycle, with no bubble between requests.
